// File: rtl/ant_nav.sv
`default_nettype none
// ============================================================================
// Module   : ant_nav
// Purpose  : Wall-following ant navigator FSM with stuck recovery; the
//            optional pheromone trail logic is enabled by macro ANT_PH_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ant_nav #(
    parameter int PH_W        = 2,
    parameter int FOLLOW_LEFT = 1,
    parameter int STUCK_MAX   = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ant_l,
    input  logic            ant_r,
    input  logic            hit,
    input  logic            escape,
`ifdef ANT_PH_EN
    input  logic [PH_W-1:0] ph_detected,
    output logic [PH_W-1:0] ph_drop,
`endif
    output logic [1:0]      move,
    output logic            stuck
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FWD       = 3'd1,
        S_TURN_WALL = 3'd2,
        S_TURN_AWAY = 3'd3,
        S_RECOVER1  = 3'd4,
        S_RECOVER2  = 3'd5,
        S_DONE      = 3'd6
    } state_t;

    localparam logic [1:0] c_MV_HALT  = 2'b00;
    localparam logic [1:0] c_MV_FWD   = 2'b01;
    localparam logic [1:0] c_MV_LEFT  = 2'b10;
    localparam logic [1:0] c_MV_RIGHT = 2'b11;
    localparam logic [1:0] c_MV_WALL  = (FOLLOW_LEFT != 0) ? c_MV_LEFT  : c_MV_RIGHT;
    localparam logic [1:0] c_MV_AWAY  = (FOLLOW_LEFT != 0) ? c_MV_RIGHT : c_MV_LEFT;
    localparam logic [7:0] c_STUCK_MAX = 8'(STUCK_MAX);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_next;
    logic [1:0] r_move;
    logic       r_stuck;
    logic       w_enter_rec;
    logic       w_near;
    logic       w_ph_seen;

    function automatic logic [1:0] f_move(input state_t s);
        case (s)
            S_FWD:       f_move = c_MV_FWD;
            S_TURN_WALL: f_move = c_MV_WALL;
            S_TURN_AWAY,
            S_RECOVER1,
            S_RECOVER2:  f_move = c_MV_AWAY;
            default:     f_move = c_MV_HALT;
        endcase
    endfunction

    assign w_near = (FOLLOW_LEFT != 0) ? ant_l : ant_r;

`ifdef ANT_PH_EN
    logic [PH_W-1:0] r_ph_drop;
    logic [PH_W-1:0] w_ph_level;

    assign w_ph_seen = |ph_detected;
    always_comb begin
        if (!w_ph_seen)
            w_ph_level = PH_W'(1);
        else if (&ph_detected)
            w_ph_level = ph_detected;
        else
            w_ph_level = ph_detected + PH_W'(1);
    end
    assign ph_drop = r_ph_drop;
`else
    assign w_ph_seen = 1'b0;
`endif

    always_comb begin
        w_next      = r_state;
        w_enter_rec = 1'b0;
        if (escape) begin
            w_next = S_DONE;
        end else begin
            case (r_state)
                S_IDLE: w_next = S_FWD;
                S_FWD: begin
                    if (hit)
                        w_next = S_TURN_AWAY;
                    else if (!w_near && w_ph_seen)
                        w_next = S_TURN_AWAY;
                    else if (!w_near)
                        w_next = S_TURN_WALL;
                end
                S_TURN_WALL: begin
                    if (r_cnt == c_STUCK_MAX) begin
                        w_next      = S_RECOVER1;
                        w_enter_rec = 1'b1;
                    end else begin
                        w_next = S_FWD;
                    end
                end
                S_TURN_AWAY: begin
                    if (r_cnt == c_STUCK_MAX) begin
                        w_next      = S_RECOVER1;
                        w_enter_rec = 1'b1;
                    end else if (!hit) begin
                        w_next = S_FWD;
                    end
                end
                S_RECOVER1: w_next = S_RECOVER2;
                S_RECOVER2: w_next = S_FWD;
                S_DONE:     w_next = S_DONE;
                default:    w_next = S_IDLE;
            endcase
        end
    end

    // r_cnt holds the number of consecutive non-forward cycles, including the current one
    always_comb begin
        w_cnt_next = 8'd0;
        if (!w_enter_rec) begin
            case (w_next)
                S_TURN_WALL, S_TURN_AWAY, S_RECOVER1, S_RECOVER2:
                    w_cnt_next = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
                default:
                    w_cnt_next = 8'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
            r_move  <= c_MV_HALT;
            r_stuck <= 1'b0;
`ifdef ANT_PH_EN
            r_ph_drop <= '0;
`endif
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            r_move  <= f_move(w_next);
            r_stuck <= w_enter_rec;
`ifdef ANT_PH_EN
            r_ph_drop <= (w_next == S_FWD) ? w_ph_level : '0;
`endif
        end
    end

    assign move  = r_move;
    assign stuck = r_stuck;

endmodule
`default_nettype wire

// File: tb/tb_ant_nav.sv
`default_nettype none
// ============================================================================
// Module   : tb_ant_nav
// Purpose  : Directed bench for ant_nav (default and STUCK_MAX=3 instances).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ant_nav;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ant_l, ant_r, hit, escape;
    logic [1:0] move, move3;
    logic       stuck, stuck3;
    int         n_checks = 0;
    int         n_fail   = 0;
`ifdef ANT_PH_EN
    logic [1:0] ph_detected;
    logic [1:0] ph_drop, ph_drop3;
`endif

    always #5 clk = ~clk;

    ant_nav #(.PH_W(2), .FOLLOW_LEFT(1), .STUCK_MAX(15)) u_dut (
        .clk(clk), .rst_n(rst_n), .ant_l(ant_l), .ant_r(ant_r),
        .hit(hit), .escape(escape),
`ifdef ANT_PH_EN
        .ph_detected(ph_detected), .ph_drop(ph_drop),
`endif
        .move(move), .stuck(stuck)
    );

    ant_nav #(.PH_W(2), .FOLLOW_LEFT(1), .STUCK_MAX(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ant_l(ant_l), .ant_r(ant_r),
        .hit(hit), .escape(escape),
`ifdef ANT_PH_EN
        .ph_detected(ph_detected), .ph_drop(ph_drop3),
`endif
        .move(move3), .stuck(stuck3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; ant_l = 1'b1; ant_r = 1'b0; hit = 1'b0; escape = 1'b0;
`ifdef ANT_PH_EN
        ph_detected = 2'd0;
`endif
        #2 rst_n = 1'b0;
        #1;
        step(); step();
        n_checks++;
        if (move !== 2'b00 || stuck !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: move=%b stuck=%b, want 00/0", move, stuck);
        end
`ifdef ANT_PH_EN
        n_checks++;
        if (ph_drop !== 2'd0) begin
            n_fail++; $display("FAIL reset_ph_drop: got %0d want 0", ph_drop);
        end
`endif
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (move !== 2'b00) begin
            n_fail++; $display("FAIL idle_after_release: move=%b want 00", move);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (move !== 2'b01) begin
                n_fail++; $display("FAIL fwd_steady[%0d]: move=%b want 01", i, move);
            end
        end
    endtask

    task automatic test_hit_pulse();
        hit = 1'b1;
        step();
        n_checks++;
        if (move !== 2'b11) begin
            n_fail++; $display("FAIL hit_pulse_turn: move=%b want 11", move);
        end
        hit = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b01) begin
            n_fail++; $display("FAIL hit_pulse_return: move=%b want 01", move);
        end
        hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (move !== 2'b11) begin
                n_fail++; $display("FAIL hit_held[%0d]: move=%b want 11", i, move);
            end
        end
        hit = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b01) begin
            n_fail++; $display("FAIL hit_held_return: move=%b want 01", move);
        end
    endtask

    task automatic test_wall();
        ant_l = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b10) begin
            n_fail++; $display("FAIL wall_turn: move=%b want 10", move);
        end
        ant_l = 1'b1;
        step();
        n_checks++;
        if (move !== 2'b01) begin
            n_fail++; $display("FAIL wall_return: move=%b want 01", move);
        end
`ifdef ANT_PH_EN
        ph_detected = 2'd2; ant_l = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b11 || ph_drop !== 2'd0) begin
            n_fail++; $display("FAIL visited_skip: move=%b ph_drop=%0d want 11/0", move, ph_drop);
        end
        ph_detected = 2'd0; ant_l = 1'b1;
        step();
        n_checks++;
        if (move !== 2'b01) begin
            n_fail++; $display("FAIL visited_return: move=%b want 01", move);
        end
`endif
    endtask

    task automatic test_hit_priority();
        hit = 1'b1; ant_l = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b11) begin
            n_fail++; $display("FAIL hit_over_wall: move=%b want 11", move);
        end
        hit = 1'b0; ant_l = 1'b1;
        step();
        n_checks++;
        if (move !== 2'b01) begin
            n_fail++; $display("FAIL hit_over_wall_return: move=%b want 01", move);
        end
    endtask

`ifdef ANT_PH_EN
    task automatic test_ph();
        logic [1:0] lv_in [3];
        logic [1:0] lv_exp [3];
        lv_in  = '{2'd0, 2'd1, 2'd3};
        lv_exp = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            ph_detected = lv_in[i];
            step();
            n_checks++;
            if (ph_drop !== lv_exp[i]) begin
                n_fail++; $display("FAIL ph_drop[%0d]: got %0d want %0d", i, ph_drop, lv_exp[i]);
            end
        end
        hit = 1'b1;
        step();
        n_checks++;
        if (ph_drop !== 2'd0 || move !== 2'b11) begin
            n_fail++; $display("FAIL ph_drop_turn: ph_drop=%0d move=%b want 0/11", ph_drop, move);
        end
        hit = 1'b0; ph_detected = 2'd0;
        step();
    endtask
`endif

    task automatic test_stuck();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        n_checks++;
        if (move3 !== 2'b01) begin
            n_fail++; $display("FAIL stuck_start: move=%b want 01", move3);
        end
        hit = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (move3 !== 2'b11 || stuck3 !== 1'b0) begin
                n_fail++; $display("FAIL stuck_turn[%0d]: move=%b stuck=%b want 11/0", i, move3, stuck3);
            end
        end
        step();
        n_checks++;
        if (move3 !== 2'b11 || stuck3 !== 1'b1) begin
            n_fail++; $display("FAIL stuck_pulse: move=%b stuck=%b want 11/1", move3, stuck3);
        end
        step();
        n_checks++;
        if (move3 !== 2'b11 || stuck3 !== 1'b0) begin
            n_fail++; $display("FAIL recover2: move=%b stuck=%b want 11/0", move3, stuck3);
        end
        step();
        n_checks++;
        if (move3 !== 2'b01) begin
            n_fail++; $display("FAIL recover_exit: move=%b want 01", move3);
        end
        hit = 1'b0;
        step();
    endtask

    task automatic test_reset_recover();
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        hit = 1'b1;
        step(); step(); step(); step();
        n_checks++;
        if (move3 !== 2'b11 || stuck3 !== 1'b1) begin
            n_fail++; $display("FAIL in_recover1: move=%b stuck=%b want 11/1", move3, stuck3);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (move3 !== 2'b00 || stuck3 !== 1'b0 || move !== 2'b00) begin
            n_fail++; $display("FAIL async_reset: move3=%b stuck3=%b move=%b want 00/0/00", move3, stuck3, move);
        end
        hit = 1'b0;
        #1 rst_n = 1'b1;
        step();
        n_checks++;
        if (move3 !== 2'b01 || move !== 2'b01) begin
            n_fail++; $display("FAIL restart: move3=%b move=%b want 01/01", move3, move);
        end
    endtask

    task automatic test_escape();
        hit = 1'b1;
        step();
        n_checks++;
        if (move !== 2'b11) begin
            n_fail++; $display("FAIL escape_pre_turn: move=%b want 11", move);
        end
        escape = 1'b1; hit = 1'b0;
        step();
        n_checks++;
        if (move !== 2'b00) begin
            n_fail++; $display("FAIL escape_done: move=%b want 00", move);
        end
        escape = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if (move !== 2'b00) begin
                n_fail++; $display("FAIL done_absorbing[%0d]: move=%b want 00", i, move);
            end
        end
    endtask

    initial begin
        test_reset();
        test_hit_pulse();
        test_wall();
        test_hit_priority();
`ifdef ANT_PH_EN
        test_ph();
`endif
        test_stuck();
        test_reset_recover();
        test_escape();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ant_nav.md
ANT_NAV -- requirements
Module: ant_nav

Interface
REQ-001 Parameter PH_W, default 2, width of the pheromone level bus.
REQ-002 Parameter FOLLOW_LEFT, default 1; 1 = left-hand wall following, 0 = right-hand.
REQ-003 Parameter STUCK_MAX, default 15, consecutive non-forward cycles before RECOVER (1..255).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 ant_l  input  1  left antenna touches wall.
REQ-007 ant_r  input  1  right antenna touches wall.
REQ-008 hit  input  1  head-on collision this cycle.
REQ-009 escape  input  1  exit reached; freezes the ant.
REQ-010 ph_detected  input  PH_W  pheromone level under the ant (0 = none); present only with ANT_PH_EN.
REQ-011 ph_drop  output  PH_W  pheromone level to deposit, registered; present only with ANT_PH_EN.
REQ-012 move  output  2  command: 00 halt, 01 forward, 10 turn left, 11 turn right; registered.
REQ-013 stuck  output  1  one-cycle pulse on entry to RECOVER.

Function
REQ-014 Moore FSM, states IDLE, FWD, TURN_WALL, TURN_AWAY, RECOVER1, RECOVER2, DONE; move decoded from the state register only.
REQ-015 near = FOLLOW_LEFT ? ant_l : ant_r; wall-side turn = left if FOLLOW_LEFT, else right; away turn = the opposite direction.
REQ-016 move per state: IDLE and DONE halt; FWD forward; TURN_WALL wall-side turn; TURN_AWAY, RECOVER1 and RECOVER2 away turn.
REQ-017 Latency: inputs sampled at edge k SHALL set move after edge k (one cycle).
REQ-018 IDLE -> FWD on the first edge after reset release, provided escape=0.
REQ-019 FWD: hit=1 -> TURN_AWAY; else near=0 and ph_detected!=0 -> TURN_AWAY (visited branch skipped); else near=0 -> TURN_WALL; else stay FWD.
REQ-020 TURN_WALL -> FWD unconditionally, so the ant never turns wall-side twice in a row.
REQ-021 TURN_AWAY: hit=1 -> stay TURN_AWAY; else -> FWD.
REQ-022 Stuck counter, 8 bits: increments each cycle the state is not FWD; clears in FWD, IDLE and DONE; saturates at 255.
REQ-023 When the counter equals STUCK_MAX in TURN_WALL or TURN_AWAY -> RECOVER1 and clear the counter; this has priority over REQ-020 and REQ-021; stuck=1 for exactly that transition cycle.
REQ-024 RECOVER1 -> RECOVER2 -> FWD unconditionally; hit is ignored during recovery.
REQ-025 escape=1 in any state -> DONE on the next edge; highest priority over all other transitions.
REQ-026 DONE is absorbing until reset; escape deasserting has no effect.
REQ-027 Simultaneous hit and near=0 in FWD: hit wins (TURN_AWAY).

Reset
REQ-028 rst_n low: state=IDLE, counter=0, move=00, stuck=0, ph_drop=0, immediately and without a clock edge.
REQ-029 Reset asserted mid-turn or mid-recovery SHALL abort it; the ant restarts from IDLE.

Configuration
REQ-030 Macro ANT_PH_EN defined: ph_detected and ph_drop ports exist; ph_drop is registered and is nonzero only on cycles where the next state is FWD.
REQ-031 With ANT_PH_EN, the ph_drop value is 1 when ph_detected=0, otherwise ph_detected+1, saturating at all-ones (2^PH_W-1).
REQ-032 Macro ANT_PH_EN undefined: both ports are absent, pheromone is treated as 0 everywhere, and REQ-019 reduces to pure wall following.

Verification
REQ-033 Release reset, ant_l=1, ant_r=0, no hit, FOLLOW_LEFT=1 -> move 00, then 01 held steady.
REQ-034 In FWD, pulse hit=1 for 1 cycle -> move 11 for 1 cycle, then 01; hit held 3 cycles -> move 11 for 3 cycles.
REQ-035 In FWD with ant_l=0 -> move 10 for 1 cycle, then 01; with ANT_PH_EN and ph_detected=2 instead -> move 11.
REQ-036 STUCK_MAX=3, hit held high -> 3 cycles of 11, stuck pulse, RECOVER 11,11, then 01 regardless of hit.
REQ-037 ANT_PH_EN, PH_W=2, ph_detected=0/1/3 while moving forward -> ph_drop=1/2/3; ph_drop=0 during turns.
REQ-038 escape=1 during TURN_AWAY -> move 00 next cycle and stays 00 after escape=0; assert rst_n mid-RECOVER -> move 00 with no clock edge.
